// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// Each operation is one radix-2 step per cycle, so every result appears a fixed 33 cycles after start.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               r_is_div;
  logic               r_div0;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_src1;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;

  logic               w_accept;
  logic               w_last;
  logic               w_signed;
  logic               w_s1neg;
  logic               w_s2neg;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  function automatic logic [WIDTH-1:0] f_fix_w(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_fix_2w(input logic [2*WIDTH-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  // Operand conditioning at start: the core always works on magnitudes
  assign w_signed = ~op[0];
  assign w_s1neg  = w_signed & src1[WIDTH-1];
  assign w_s2neg  = w_signed & src2[WIDTH-1];
  assign w_mag1   = f_fix_w(src1, w_s1neg);
  assign w_mag2   = f_fix_w(src2, w_s2neg);

  // Iteration step: shift-add for multiply, restoring shift-subtract for divide
  assign w_madd  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_opb};
  assign w_diff  = w_shift[WIDTH-1:0] - r_opb;

  // Sign correction applied in FIN
  assign w_prod = f_fix_2w({r_acc_hi, r_acc_lo}, r_neg_q);
  assign w_quo  = f_fix_w(r_acc_lo, r_neg_q);
  assign w_rem  = f_fix_w(r_acc_hi, r_neg_r);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (r_state == S_FIN);
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
      if (r_state == S_FIN) begin
        if (!r_is_div) begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end else if (r_div0) begin
          r_hi <= r_src1;
          r_lo <= '1;
        end else begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end
      end else if (r_state == S_IDLE && !start) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded at start
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_div <= op[1];
      r_div0   <= (src2 == '0);
      r_neg_q  <= w_s1neg ^ w_s2neg;
      r_neg_r  <= w_s1neg;
      r_src1   <= src1;
      r_acc_hi <= '0;
      r_opb    <= op[1] ? w_mag2 : w_mag1;
      r_acc_lo <= op[1] ? w_mag1 : w_mag2;
    end else if (r_state == S_CALC) begin
      if (r_is_div) begin
        r_acc_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
      end else begin
        r_acc_hi <= w_madd[WIDTH:1];
        r_acc_lo <= {w_madd[0], r_acc_lo[WIDTH-1:1]};
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: directed corner cases plus randomized operations,
// each checked against a 64-bit arithmetic model of HI/LO.
module tb_muldiv_hilo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] src1, src2, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src1(src1), .src2(src2), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl);
    longint     sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    rh = p[63:32];
    rl = p[31:0];
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit we_at_start);
    logic [31:0] eh, el;
    int nbusy, ndone;
    model(o, a, b, eh, el);
    op = o; src1 = a; src2 = b; start = 1'b1;
    if (we_at_start) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = ~m_lo;
    end
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); src1 = $urandom; src2 = $urandom;
    if (we_at_start) begin
      chk("start_beats_we_hi", hi, m_hi);
      chk("start_beats_we_lo", lo, m_lo);
    end
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < 33; i++) begin
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) ndone++;
      if (i == 16) begin
        chk("hold_hi_calc", hi, m_hi);
        chk("hold_lo_calc", lo, m_lo);
      end
      if (disturb && i == 10) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end
      if (disturb && i == 11) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      tick();
    end
    chk("busy_cycles", 32'(nbusy), 32'd33);
    chk("no_early_done", 32'(ndone), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("result_hi", hi, eh);
    chk("result_lo", lo, el);
    m_hi = eh;
    m_lo = el;
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int          ndone;
    logic [1:0]  o;
    logic [31:0] a, b;

    rst = 1'b1; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b0;
    tick();

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFF1);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(2'b11, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi", hi, 32'h1234_5678);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi", hi, 32'hA5A5_A5A5);
    chk("mtlo", lo, 32'hA5A5_A5A5);
    m_hi = 32'hA5A5_A5A5;
    m_lo = 32'hA5A5_A5A5;

    run_op(2'b11, 32'd100, 32'd7, 1'b1, 1'b0);
    chk("divu_disturb_lo", lo, 32'd14);
    chk("divu_disturb_hi", hi, 32'd2);

    op = 2'b01; src1 = 32'd3; src2 = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    ndone = 0;
    repeat (40) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_lo_hold", lo, 32'd0);

    run_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b0);
    chk("multu_after_abort", lo, 32'd12);

    run_op(2'b11, 32'd1000, 32'd7, 1'b0, 1'b1);
    chk("start_we_lo_result", lo, 32'd142);

    for (int k = 0; k < 30; k++) begin
      hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = $urandom;
      tick();
      if (hi_we) m_hi = wdata;
      if (lo_we) m_lo = wdata;
      hi_we = 1'b0; lo_we = 1'b0;
      chk("rand_mt_hi", hi, m_hi);
      chk("rand_mt_lo", lo, m_lo);
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
      run_op(o, a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
Iterative multiply/divide unit that owns the architectural HI/LO registers. It sits in EX, beside the ALU, and its hi/lo outputs feed the writeback result mux as the HI and LO sources for MFHI and MFLO. It executes MULT, MULTU, DIV and DIVU in a fixed number of cycles and asserts busy so that hazard control stalls the pipeline. It also services MTHI and MTLO writes.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  launches the operation selected by op; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src1  input  WIDTH  multiplicand / dividend (rs)
src2  input  WIDTH  multiplier / divisor (rt)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  an operation is in progress
done  output  1  one-cycle pulse: new HI/LO are visible
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts the operation; no partial result is written.
- FSM states:
  - IDLE: on start=1, latch op, src1 and src2, compute operand magnitudes and result sign, and go to CALC with counter=0. busy=1 from the next cycle.
  - CALC: one radix-2 step per cycle. Multiply is shift-add over the 2*WIDTH product. Divide is restoring shift-subtract. counter increments each cycle. After WIDTH steps (counter==WIDTH-1), go to FIN.
  - FIN: apply sign correction and write hi/lo. Next state is IDLE. busy=0 and done=1 in the cycle after the FIN edge.
- Latency: start sampled at edge E0. CALC runs on edges E1..E32. The E33 edge writes hi/lo, clears busy and sets done. The new result is visible 33 cycles after start. Latency is fixed and data-independent, including divide-by-zero.
- done is a one-cycle pulse; it is 0 in every other cycle.
- Multiply results: hi = product[2W-1:W], lo = product[W-1:0]. MULT is signed two's complement; MULTU is unsigned.
- Signed divide:
  - The quotient truncates toward zero; the remainder takes the sign of the dividend. lo = quotient, hi = remainder.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=the raw src1 value as latched.
- start while busy: ignored; the operation in flight is unaffected.
- hi_we / lo_we:
  - Honoured only when busy=0 and no start is accepted in the same cycle. hi <= wdata or lo <= wdata at the edge. Both may be asserted together.
  - While busy=1 they are ignored.
  - If start=1 in IDLE in the same cycle, start wins and the writes are dropped.
- hi/lo hold their values at all times except a FIN write, an accepted MTHI/MTLO write, or reset. During CALC, hi/lo still show the previous values.
- Operands are latched at start; changes on src1, src2 or op during CALC have no effect.

Test Plan:
- MULTU src1=0xFFFFFFFF src2=0xFFFFFFFF -> done exactly 33 cycles after start, busy high for those 33 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- MULT src1=0xFFFFFFFD (-3) src2=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV src1=0xFFFFFFF9 (-7) src2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU src1=0x12345678 src2=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- In IDLE, hi_we=1 lo_we=1 wdata=0xA5A5A5A5 -> both registers read 0xA5A5A5A5 next cycle. Then start DIVU 100/7 and pulse start plus hi_we mid-CALC -> both ignored; final lo=14, hi=2.
- Start MULTU 3*4, assert rst at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse. A new start then completes normally with lo=12.
- start and lo_we asserted in the same IDLE cycle -> lo is not written from wdata; the operation runs and lo gets the result.
